// File: rtl/mips_pkg.sv
// Shared types for the forwarding/hazard slice: select codes, stall FSM states and the
// layout of the EX/MEM and MEM/WB tracking records.
package mips_pkg;

    localparam int unsigned SelW = 3;
    localparam logic [SelW-1:0] SelRegFile = 3'b000;
    localparam logic [SelW-1:0] SelExMem   = 3'b001;
    localparam logic [SelW-1:0] SelMemWb   = 3'b010;

    // Register indices are zero-extended into a fixed-width field so the records stay unparameterised.
    localparam int unsigned MaxRegBits = 8;
    typedef logic [MaxRegBits-1:0] reg_idx_t;

    typedef enum logic {StIdle, StStall} hz_state_e;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     regwrite;
        logic     memread;
    } ex_mem_rec_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     regwrite;
    } mem_wb_rec_t;

endpackage

// File: rtl/fwd_select.sv
// Per-source forwarding compare and operand mux; the younger EX/MEM producer wins over MEM/WB.
module fwd_select
    import mips_pkg::*;
#(
    parameter int unsigned NBITS    = 32,
    parameter int unsigned SEL_BITS = 3
) (
    input  reg_idx_t          i_rs,
    input  ex_mem_rec_t       i_ex_mem,
    input  mem_wb_rec_t       i_mem_wb,
    input  logic [NBITS-1:0]  i_regfile,
    input  logic [NBITS-1:0]  i_ex_mem_val,
    input  logic [NBITS-1:0]  i_mem_wb_val,
    output logic [NBITS-1:0]  o_operand,
    output logic [SEL_BITS-1:0] o_sel
);

    logic            ex_hit;
    logic            wb_hit;
    logic [SelW-1:0] code;

    always_comb begin
        // A load's result is not in EX/MEM yet, so it is never a forwarding source there.
        ex_hit = i_ex_mem.valid && i_ex_mem.regwrite && !i_ex_mem.memread &&
                 (i_ex_mem.rd != '0) && (i_ex_mem.rd == i_rs);
        wb_hit = i_mem_wb.valid && i_mem_wb.regwrite &&
                 (i_mem_wb.rd != '0) && (i_mem_wb.rd == i_rs);
        code      = SelRegFile;
        o_operand = i_regfile;
        if (ex_hit) begin
            code      = SelExMem;
            o_operand = i_ex_mem_val;
        end else if (wb_hit) begin
            code      = SelMemWb;
            o_operand = i_mem_wb_val;
        end
        o_sel = SEL_BITS'(code);
    end

endmodule

// File: rtl/forward_hazard_unit.sv
// Operand forwarding from EX/MEM and MEM/WB plus load-use stall generation for a 5-stage pipe.
module forward_hazard_unit
    import mips_pkg::*;
#(
    parameter int unsigned NBITS         = 32,
    parameter int unsigned NREG_BITS     = 5,
    parameter int unsigned NSRC          = 2,
    parameter int unsigned LOAD_STALL    = 1,
    parameter int unsigned CORTOCIRCUITO = 3
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_flush,
    input  logic                          i_ID_EX_valid,
    input  logic [NREG_BITS-1:0]          i_ID_EX_rd,
    input  logic                          i_ID_EX_regwrite,
    input  logic                          i_ID_EX_memread,
    input  logic [NSRC*NREG_BITS-1:0]     i_ID_EX_rs,
    input  logic [NSRC*NREG_BITS-1:0]     i_IF_ID_rs,
    input  logic                          i_IF_ID_valid,
    input  logic [NSRC*NBITS-1:0]         i_ID_EX_Registro,
    input  logic [NBITS-1:0]              i_EX_MEM_Registro,
    input  logic [NBITS-1:0]              i_MEM_WR_Registro,
    output logic [NSRC*NBITS-1:0]         o_toALU,
    output logic [NSRC*CORTOCIRCUITO-1:0] o_sel,
    output logic                          o_stall,
    output logic                          o_bubble
);

    localparam int unsigned CntW = $clog2(LOAD_STALL + 1);

    ex_mem_rec_t     ex_mem_d, ex_mem_q;
    mem_wb_rec_t     mem_wb_d, mem_wb_q;
    hz_state_e       state_d, state_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic            load_use;
    logic            stall_raw;

    always_comb begin
        ex_mem_d.valid    = i_ID_EX_valid && !i_flush;
        ex_mem_d.rd       = reg_idx_t'(i_ID_EX_rd);
        ex_mem_d.regwrite = i_ID_EX_regwrite;
        ex_mem_d.memread  = i_ID_EX_memread;
        mem_wb_d.valid    = ex_mem_q.valid;
        mem_wb_d.rd       = ex_mem_q.rd;
        mem_wb_d.regwrite = ex_mem_q.regwrite;
    end

    always_comb begin
        load_use = 1'b0;
        if (i_ID_EX_valid && i_ID_EX_memread && !i_flush && (i_ID_EX_rd != '0) && i_IF_ID_valid) begin
            for (int i = 0; i < NSRC; i++) begin
                if (i_IF_ID_rs[i*NREG_BITS +: NREG_BITS] == i_ID_EX_rd) begin
                    load_use = 1'b1;
                end
            end
        end
    end

    // The first stall cycle is raised combinationally from IDLE; STALL covers the remainder.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load_use) begin
                    stall_raw = 1'b1;
                    if (LOAD_STALL > 1) begin
                        state_d = StStall;
                        cnt_d   = CntW'(LOAD_STALL - 1);
                    end
                end
            end
            StStall: begin
                stall_raw = 1'b1;
                if (i_flush || (cnt_q <= CntW'(1))) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ex_mem_q <= '0;
            mem_wb_q <= '0;
            state_q  <= StIdle;
            cnt_q    <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
        end
    end

    // Reset masks the combinational hazard path so stall drops the instant reset asserts.
    assign o_stall  = i_reset && stall_raw;
    assign o_bubble = i_reset && stall_raw;

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        reg_idx_t rs_ext;
        assign rs_ext = reg_idx_t'(i_ID_EX_rs[g*NREG_BITS +: NREG_BITS]);

        fwd_select #(
            .NBITS   (NBITS),
            .SEL_BITS(CORTOCIRCUITO)
        ) u_fwd_select (
            .i_rs        (rs_ext),
            .i_ex_mem    (ex_mem_q),
            .i_mem_wb    (mem_wb_q),
            .i_regfile   (i_ID_EX_Registro[g*NBITS +: NBITS]),
            .i_ex_mem_val(i_EX_MEM_Registro),
            .i_mem_wb_val(i_MEM_WR_Registro),
            .o_operand   (o_toALU[g*NBITS +: NBITS]),
            .o_sel       (o_sel[g*CORTOCIRCUITO +: CORTOCIRCUITO])
        );
    end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench: one unit with a single-cycle load stall and one with a three-cycle stall.
module tb_forward_hazard_unit;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        id_ex_valid;
    logic [4:0]  id_ex_rd;
    logic        id_ex_rw;
    logic        id_ex_mr;
    logic [9:0]  id_ex_rs;
    logic [9:0]  if_id_rs;
    logic        if_id_valid;
    logic [63:0] id_ex_reg;
    logic [31:0] ex_mem_val;
    logic [31:0] mem_wb_val;

    logic [63:0] to_alu1, to_alu3;
    logic [5:0]  sel1, sel3;
    logic        stall1, stall3, bubble1, bubble3;

    int n_checks = 0;
    int n_errors = 0;

    forward_hazard_unit #(.LOAD_STALL(1)) u_dut1 (
        .i_clk            (clk),
        .i_reset          (rst_n),
        .i_flush          (flush),
        .i_ID_EX_valid    (id_ex_valid),
        .i_ID_EX_rd       (id_ex_rd),
        .i_ID_EX_regwrite (id_ex_rw),
        .i_ID_EX_memread  (id_ex_mr),
        .i_ID_EX_rs       (id_ex_rs),
        .i_IF_ID_rs       (if_id_rs),
        .i_IF_ID_valid    (if_id_valid),
        .i_ID_EX_Registro (id_ex_reg),
        .i_EX_MEM_Registro(ex_mem_val),
        .i_MEM_WR_Registro(mem_wb_val),
        .o_toALU          (to_alu1),
        .o_sel            (sel1),
        .o_stall          (stall1),
        .o_bubble         (bubble1)
    );

    forward_hazard_unit #(.LOAD_STALL(3)) u_dut3 (
        .i_clk            (clk),
        .i_reset          (rst_n),
        .i_flush          (flush),
        .i_ID_EX_valid    (id_ex_valid),
        .i_ID_EX_rd       (id_ex_rd),
        .i_ID_EX_regwrite (id_ex_rw),
        .i_ID_EX_memread  (id_ex_mr),
        .i_ID_EX_rs       (id_ex_rs),
        .i_IF_ID_rs       (if_id_rs),
        .i_IF_ID_valid    (if_id_valid),
        .i_ID_EX_Registro (id_ex_reg),
        .i_EX_MEM_Registro(ex_mem_val),
        .i_MEM_WR_Registro(mem_wb_val),
        .o_toALU          (to_alu3),
        .o_sel            (sel3),
        .o_stall          (stall3),
        .o_bubble         (bubble3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [4:0] rd, input logic rw, input logic mr);
        id_ex_valid = v;
        id_ex_rd    = rd;
        id_ex_rw    = rw;
        id_ex_mr    = mr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        id_ex_rs    = '0;
        if_id_rs    = '0;
        if_id_valid = 1'b0;
        id_ex_reg   = {32'h2222_2222, 32'h1111_1111};
        ex_mem_val  = 32'hDEAD_BEEF;
        mem_wb_val  = 32'hCAFE_F00D;
        // Load-use pattern present while reset is held: outputs must stay quiet.
        drive_ex(1'b1, 5'd5, 1'b1, 1'b1);
        if_id_valid = 1'b1;
        if_id_rs    = {5'd0, 5'd5};
        #12;
        check("rst_stall1", 64'(stall1), 64'd0);
        check("rst_stall3", 64'(stall3), 64'd0);
        check("rst_bubble1", 64'(bubble1), 64'd0);
        check("rst_sel", 64'(sel1), 64'd0);
        check("rst_toalu", to_alu1, {32'h2222_2222, 32'h1111_1111});

        tick();
        rst_n = 1'b1;
        drive_ex(1'b1, 5'd8, 1'b1, 1'b0);
        if_id_rs = '0;
        id_ex_rs = '0;
        #1;
        check("nohaz_stall1", 64'(stall1), 64'd0);
        tick();

        // EX/MEM holds rd=8 writer
        id_ex_rs = {5'd3, 5'd8};
        drive_ex(1'b1, 5'd8, 1'b1, 1'b0);
        #1;
        check("exfwd_sel", 64'(sel1), 64'({3'b000, 3'b001}));
        check("exfwd_toalu", to_alu1, {32'h2222_2222, 32'hDEAD_BEEF});
        tick();

        // rd=8 in both EX/MEM and MEM/WB
        id_ex_rs = {5'd8, 5'd8};
        drive_ex(1'b1, 5'd0, 1'b1, 1'b0);
        #1;
        check("prio_sel", 64'(sel1), 64'({3'b001, 3'b001}));
        check("prio_toalu", to_alu1, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
        tick();

        // EX/MEM: rd=0 writer; MEM/WB: rd=8 writer
        id_ex_rs = {5'd8, 5'd0};
        drive_ex(1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        check("r0_wbfwd_sel", 64'(sel1), 64'({3'b010, 3'b000}));
        check("r0_wbfwd_toalu", to_alu1, {32'hCAFE_F00D, 32'h1111_1111});
        tick();

        // Load-use: load rd=5 in EX, consumer rs0=5 in ID
        id_ex_rs = '0;
        drive_ex(1'b1, 5'd5, 1'b1, 1'b1);
        if_id_valid = 1'b1;
        if_id_rs    = {5'd0, 5'd5};
        #1;
        check("lu_stall1", 64'(stall1), 64'd1);
        check("lu_bubble1", 64'(bubble1), 64'd1);
        check("lu_stall3", 64'(stall3), 64'd1);
        tick();

        drive_ex(1'b0, 5'd0, 1'b0, 1'b0);
        id_ex_rs = {5'd0, 5'd5};
        #1;
        check("lu1_stall1", 64'(stall1), 64'd0);
        check("lu1_stall3", 64'(stall3), 64'd1);
        check("lu1_sel_load", 64'(sel1), 64'd0);
        tick();

        drive_ex(1'b1, 5'd10, 1'b1, 1'b0);
        id_ex_rs = {5'd0, 5'd5};
        if_id_rs = '0;
        #1;
        check("lu2_sel", 64'(sel1), 64'({3'b000, 3'b010}));
        check("lu2_toalu", to_alu1, {32'h2222_2222, 32'hCAFE_F00D});
        check("lu2_stall1", 64'(stall1), 64'd0);
        check("lu2_stall3", 64'(stall3), 64'd1);
        check("lu2_bubble3", 64'(bubble3), 64'd1);
        tick();

        drive_ex(1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        check("lu3_stall3", 64'(stall3), 64'd0);
        check("lu3_bubble3", 64'(bubble3), 64'd0);
        tick();

        // Flush during second stall cycle ends the stall
        drive_ex(1'b1, 5'd5, 1'b1, 1'b1);
        if_id_rs = {5'd0, 5'd5};
        #1;
        check("fl_c1_stall3", 64'(stall3), 64'd1);
        tick();
        drive_ex(1'b0, 5'd0, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        check("fl_c2_stall3", 64'(stall3), 64'd1);
        tick();
        flush = 1'b0;
        #1;
        check("fl_c3_stall3", 64'(stall3), 64'd0);
        check("fl_c3_bubble3", 64'(bubble3), 64'd0);
        tick();

        // Flushed writer rd=9 must not be forwarded
        drive_ex(1'b1, 5'd9, 1'b1, 1'b0);
        if_id_rs = '0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive_ex(1'b0, 5'd0, 1'b0, 1'b0);
        id_ex_rs = {5'd0, 5'd9};
        #1;
        check("flkill_sel", 64'(sel1), 64'd0);
        check("flkill_toalu", to_alu1, {32'h2222_2222, 32'h1111_1111});
        tick();

        // Reset pulse in the middle of a 3-cycle stall
        drive_ex(1'b1, 5'd5, 1'b1, 1'b1);
        if_id_rs = {5'd0, 5'd5};
        tick();
        drive_ex(1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        check("rstmid_pre_stall3", 64'(stall3), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_stall3", 64'(stall3), 64'd0);
        check("rstmid_bubble3", 64'(bubble3), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rstrel_stall3", 64'(stall3), 64'd0);
        tick();
        check("rstrel_edge_stall3", 64'(stall3), 64'd0);
        check("rstrel_edge_bubble3", 64'(bubble3), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
